reg_update_scheduler: RTL and testbench

Arbitrated, frame-synchronous write scheduler for the PWM/output control registers. Two write requesters (the SPI peripheral's decoded writes and a local on-chip sequencer) share one register file holding the five control registers. Accepted writes are staged in shadow registers and committed to the live outputs only on a PWM period boundary, so the outputs and the PWM datapath never see a mid-period change. A bypass mode allows immediate updates.

---
 rtl/reg_update_scheduler.sv | 142 ++++++++++++++
 tb/tb_reg_update_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_update_scheduler.sv
// Two-requester, frame-synchronous write scheduler for the PWM/output control
// registers. Writes are staged in shadows and committed on frame_tick, or go
// straight to the live register while bypass is high.
module reg_update_scheduler #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              frame_tick,
  input  logic              bypass,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              pending,
  output logic              err_addr,
  output logic [7:0]        commit_cnt
);

  localparam int unsigned NUM_REGS = 5;
  localparam int unsigned CNT_W    = 8;

  // rr_q = 0 favours A, 1 favours B
  logic rr_q, rr_d;
  logic grant_a, grant_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [DATA_W-1:0]   live_q   [NUM_REGS];
  logic [DATA_W-1:0]   live_d   [NUM_REGS];
  logic [DATA_W-1:0]   shadow_q [NUM_REGS];
  logic [DATA_W-1:0]   shadow_d [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_q, dirty_d;
  logic                pending_q, pending_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                addr_hit;

  // Round-robin arbitration; grant is combinational in the request cycle
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    rr_d    = rr_q;
    if (!rst) begin
      if (a_valid && (!b_valid || !rr_q)) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
    if (grant_a) begin
      rr_d = 1'b1;
    end else if (grant_b) begin
      rr_d = 1'b0;
    end
    a_ready = grant_a;
    b_ready = grant_b;
    wr_en   = grant_a | grant_b;
    wr_addr = grant_b ? b_addr : a_addr;
    wr_data = grant_b ? b_data : a_data;
  end

  // Commit staged values on the tick, then apply this cycle's write on top
  always_comb begin
    live_d   = live_q;
    shadow_d = shadow_q;
    dirty_d  = dirty_q;
    cnt_d    = cnt_q;
    addr_hit = 1'b0;
    if (frame_tick) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (dirty_q[i]) begin
          live_d[i] = shadow_q[i];
        end
      end
      dirty_d = '0;
      if (|dirty_q) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (wr_en) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_addr == ADDR_W'(i)) begin
          addr_hit    = 1'b1;
          shadow_d[i] = wr_data;
          if (bypass) begin
            live_d[i]  = wr_data;
            dirty_d[i] = 1'b0;
          end else begin
            dirty_d[i] = 1'b1;
          end
        end
      end
    end
    err_d     = wr_en && !addr_hit;
    pending_d = |dirty_d;
  end

  // State registers with synchronous reset; reset also masks frame_tick
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q      <= 1'b0;
      dirty_q   <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        live_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      rr_q      <= rr_d;
      dirty_q   <= dirty_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      live_q    <= live_d;
      shadow_q  <= shadow_d;
    end
  end

  assign en_reg_out_7_0  = live_q[0];
  assign en_reg_out_15_8 = live_q[1];
  assign en_reg_pwm_7_0  = live_q[2];
  assign en_reg_pwm_15_8 = live_q[3];
  assign pwm_duty_cycle  = live_q[4];
  assign pending         = pending_q;
  assign err_addr        = err_q;
  assign commit_cnt      = cnt_q;

endmodule

// File: tb/tb_reg_update_scheduler.sv
// Directed bench for reg_update_scheduler: a cycle model of the register file
// checked every cycle, plus hand-computed checkpoints along the scenario.
module tb_reg_update_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, b_valid, a_ready, b_ready;
  logic [6:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic       frame_tick, bypass;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       pending, err_addr;
  logic [7:0] commit_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  reg_update_scheduler #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .frame_tick(frame_tick), .bypass(bypass),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .pending(pending), .err_addr(err_addr),
    .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: live/shadow/dirty per address, favoured requester, counters
  bit [7:0] m_live [5];
  bit [7:0] m_shadow [5];
  bit       m_dirty [5];
  bit       m_favour_b, m_pend, m_err, m_valid;
  bit [7:0] m_cnt;

  initial begin
    m_valid = 1'b0;
    forever begin : model_step
      bit         ga, gb, any;
      logic [6:0] ad;
      logic [7:0] dt;
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < 5; i++) begin
          m_live[i] = 8'h00; m_shadow[i] = 8'h00; m_dirty[i] = 1'b0;
        end
        m_favour_b = 1'b0; m_pend = 1'b0; m_err = 1'b0; m_cnt = 8'h00;
        m_valid = 1'b1;
      end else begin
        ga = a_valid && (!b_valid || !m_favour_b);
        gb = b_valid && !ga;
        ad = gb ? b_addr : a_addr;
        dt = gb ? b_data : a_data;
        if (frame_tick) begin
          any = 1'b0;
          for (int i = 0; i < 5; i++) begin
            if (m_dirty[i]) begin
              any = 1'b1;
              m_live[i] = m_shadow[i];
            end
            m_dirty[i] = 1'b0;
          end
          if (any) m_cnt = m_cnt + 8'd1;
        end
        m_err = (ga || gb) && (ad >= 7'd5);
        if ((ga || gb) && (ad < 7'd5)) begin
          m_shadow[ad[2:0]] = dt;
          if (bypass) begin
            m_live[ad[2:0]]  = dt;
            m_dirty[ad[2:0]] = 1'b0;
          end else begin
            m_dirty[ad[2:0]] = 1'b1;
          end
        end
        if (ga) m_favour_b = 1'b1;
        else if (gb) m_favour_b = 1'b0;
        m_pend = 1'b0;
        for (int i = 0; i < 5; i++) m_pend = m_pend | m_dirty[i];
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge
  initial begin
    forever begin : cmp_step
      bit exp_a, exp_b;
      @(negedge clk);
      if (m_valid) begin
        exp_a = a_valid && !rst && (!b_valid || !m_favour_b);
        exp_b = b_valid && !rst && !exp_a;
        chk("m_a_ready", 32'(a_ready), 32'(exp_a));
        chk("m_b_ready", 32'(b_ready), 32'(exp_b));
        chk("m_out_7_0", 32'(en_reg_out_7_0), 32'(m_live[0]));
        chk("m_out_15_8", 32'(en_reg_out_15_8), 32'(m_live[1]));
        chk("m_pwm_7_0", 32'(en_reg_pwm_7_0), 32'(m_live[2]));
        chk("m_pwm_15_8", 32'(en_reg_pwm_15_8), 32'(m_live[3]));
        chk("m_duty", 32'(pwm_duty_cycle), 32'(m_live[4]));
        chk("m_pending", 32'(pending), 32'(m_pend));
        chk("m_err_addr", 32'(err_addr), 32'(m_err));
        chk("m_commit_cnt", 32'(commit_cnt), 32'(m_cnt));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one write from A (sel=0) or B (sel=1), holding it until ready
  task automatic write(input bit sel, input logic [6:0] ad, input logic [7:0] dt);
    bit got;
    if (sel) begin b_valid = 1'b1; b_addr = ad; b_data = dt; end
    else     begin a_valid = 1'b1; a_addr = ad; a_data = dt; end
    got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      got = sel ? b_ready : a_ready;
      step();
    end
    if (sel) b_valid = 1'b0; else a_valid = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL write_timeout: got no ready, expected ready within 16 cycles");
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int grants [4];
    int na, nb;
    bit ga, gb;
    rst = 1'b1; frame_tick = 1'b0; bypass = 1'b0;
    a_valid = 1'b1; a_addr = 7'h00; a_data = 8'hAA;
    b_valid = 1'b1; b_addr = 7'h01; b_data = 8'hBB;

    // Reset with both requesters valid
    @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", 32'(a_ready), 0);
    chk("rst_b_ready", 32'(b_ready), 0);
    chk("rst_commit_cnt", 32'(commit_cnt), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_duty", 32'(pwm_duty_cycle), 0);
    step();
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;

    // Staged write held until the tick
    write(1'b0, 7'h04, 8'h80);
    repeat (3) begin
      @(negedge clk);
      chk("staged_duty_hold", 32'(pwm_duty_cycle), 0);
      chk("staged_pending", 32'(pending), 1);
      step();
    end
    frame_tick = 1'b1;
    @(negedge clk);
    chk("staged_duty_tick_cycle", 32'(pwm_duty_cycle), 0);
    step();
    frame_tick = 1'b0;
    chk("staged_duty_after", 32'(pwm_duty_cycle), 32'h80);
    chk("staged_commit_cnt", 32'(commit_cnt), 1);
    chk("staged_pending_fall", 32'(pending), 0);

    // Write coinciding with the tick lands in the next commit
    frame_tick = 1'b1;
    write(1'b1, 7'h02, 8'h5A);
    frame_tick = 1'b0;
    chk("coinc_pwm_7_0_hold", 32'(en_reg_pwm_7_0), 0);
    chk("coinc_pending", 32'(pending), 1);
    chk("coinc_cnt_hold", 32'(commit_cnt), 1);
    tick();
    chk("coinc_pwm_7_0", 32'(en_reg_pwm_7_0), 32'h5A);
    chk("coinc_cnt", 32'(commit_cnt), 2);

    // Contention: A writes 0x00, B writes 0x01, two values each
    a_valid = 1'b1; a_addr = 7'h00; a_data = 8'h21;
    b_valid = 1'b1; b_addr = 7'h01; b_data = 8'h31;
    na = 0; nb = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ga = a_ready; gb = b_ready;
      grants[k] = ga ? 1 : (gb ? 2 : 0);
      step();
      if (ga) begin na++; if (na == 2) a_valid = 1'b0; else a_data = 8'h22; end
      if (gb) begin nb++; if (nb == 2) b_valid = 1'b0; else b_data = 8'h32; end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    chk("cont_grant0", 32'(grants[0]), 1);
    chk("cont_grant1", 32'(grants[1]), 2);
    chk("cont_grant2", 32'(grants[2]), 1);
    chk("cont_grant3", 32'(grants[3]), 2);
    tick();
    chk("cont_out_7_0", 32'(en_reg_out_7_0), 32'h22);
    chk("cont_out_15_8", 32'(en_reg_out_15_8), 32'h32);
    chk("cont_cnt", 32'(commit_cnt), 3);

    // Unmapped address then bypass write
    write(1'b0, 7'h05, 8'hFF);
    chk("unmapped_err", 32'(err_addr), 1);
    chk("unmapped_pending", 32'(pending), 0);
    step();
    chk("unmapped_err_clear", 32'(err_addr), 0);
    chk("unmapped_duty", 32'(pwm_duty_cycle), 32'h80);
    bypass = 1'b1;
    write(1'b0, 7'h03, 8'h11);
    bypass = 1'b0;
    chk("bypass_pwm_15_8", 32'(en_reg_pwm_15_8), 32'h11);
    chk("bypass_pending", 32'(pending), 0);
    chk("bypass_cnt", 32'(commit_cnt), 3);

    // Staged writes discarded by reset, then an empty commit
    for (int i = 0; i < 5; i++) write(1'b0, 7'(i), 8'(8'h40 + i));
    chk("mid_pending", 32'(pending), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    tick();
    chk("mid_cnt", 32'(commit_cnt), 0);
    chk("mid_pending_after", 32'(pending), 0);
    chk("mid_out_7_0", 32'(en_reg_out_7_0), 0);
    chk("mid_out_15_8", 32'(en_reg_out_15_8), 0);
    chk("mid_pwm_7_0", 32'(en_reg_pwm_7_0), 0);
    chk("mid_pwm_15_8", 32'(en_reg_pwm_15_8), 0);
    chk("mid_duty", 32'(pwm_duty_cycle), 0);
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
